// File: rtl/tristate_pkg.sv
// ============================================================================
// Module   : tristate_pkg
// Purpose  : Shared types and constants for the one-bit tri-state driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tristate_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef logic [CNT_W_DEFAULT-1:0] drv_cnt_t;

  localparam drv_cnt_t DRV_CNT_MAX = '1;

endpackage : tristate_pkg

`default_nettype wire

// File: rtl/tristate_buffer_one_bit_if.sv
// ============================================================================
// Module   : tristate_buffer_one_bit_if
// Purpose  : Enable/data inputs and registered drive-status sideband of one
//            bus driver. drv_cycles exists only with TRISTATE_DRIVE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tristate_buffer_one_bit_if
  import tristate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic din;
  logic sel;
  logic drv_q;
  logic drv_rise;
`ifdef TRISTATE_DRIVE_STATS_EN
  logic [CNT_W-1:0] drv_cycles;
`endif

`ifdef TRISTATE_DRIVE_STATS_EN
  modport master (output din, output sel, input drv_q, input drv_rise, input drv_cycles);
  modport slave  (input din, input sel, output drv_q, output drv_rise, output drv_cycles);
`else
  modport master (output din, output sel, input drv_q, input drv_rise);
  modport slave  (input din, input sel, output drv_q, output drv_rise);
`endif

endinterface : tristate_buffer_one_bit_if

`default_nettype wire

// File: rtl/tristate_drive_stats.sv
// ============================================================================
// Module   : tristate_drive_stats
// Purpose  : Registered enable status, rising-edge pulse and (with
//            TRISTATE_DRIVE_STATS_EN) a saturating drive-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tristate_drive_stats
  import tristate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             sel,
  output logic                  drv_q,
  output logic                  drv_rise
`ifdef TRISTATE_DRIVE_STATS_EN
  ,
  output logic [CNT_W-1:0]      drv_cycles
`endif
);

  logic r_drv_q;
  logic r_drv_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drv_q    <= 1'b0;
      r_drv_rise <= 1'b0;
    end else begin
      r_drv_q    <= sel;
      r_drv_rise <= sel & ~r_drv_q;
    end
  end

  assign drv_q    = r_drv_q;
  assign drv_rise = r_drv_rise;

`ifdef TRISTATE_DRIVE_STATS_EN
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_drv_cycles;

  // Holds at all-ones once reached; the count never wraps back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drv_cycles <= '0;
    end else if (sel && (r_drv_cycles != c_cnt_max)) begin
      r_drv_cycles <= r_drv_cycles + 1'b1;
    end
  end

  assign drv_cycles = r_drv_cycles;
`endif

endmodule : tristate_drive_stats

`default_nettype wire

// File: rtl/tristate_buffer_one_bit.sv
// ============================================================================
// Module   : tristate_buffer_one_bit
// Purpose  : Single-bit tri-state bus driver with clocked drive sideband.
//            Optional counter enabled by macro TRISTATE_DRIVE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tristate_buffer_one_bit
  import tristate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  tristate_buffer_one_bit_if.slave  bus,
  output wire                       dout
);

  // Purely combinational; an unknown sel merges din with Z and yields X.
  assign dout = bus.sel ? bus.din : 1'bz;

  tristate_drive_stats #(
    .CNT_W      (CNT_W)
  ) u_stats (
    .clk        (clk),
    .rst        (rst),
    .sel        (bus.sel),
    .drv_q      (bus.drv_q),
    .drv_rise   (bus.drv_rise)
`ifdef TRISTATE_DRIVE_STATS_EN
    ,
    .drv_cycles (bus.drv_cycles)
`endif
  );

endmodule : tristate_buffer_one_bit

`default_nettype wire

// File: tb/tb_tristate_buffer_one_bit.sv
// ============================================================================
// Module   : tb_tristate_buffer_one_bit
// Purpose  : Directed bench; two identical DUTs on a pulled-up and a
//            pulled-down net so "not driven" is observable as 1/0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tristate_buffer_one_bit;

  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  wire  dout_pu;
  wire  dout_pd;
  pullup   (dout_pu);
  pulldown (dout_pd);

  tristate_buffer_one_bit_if #(.CNT_W(CNT_W)) bus_pu ();
  tristate_buffer_one_bit_if #(.CNT_W(CNT_W)) bus_pd ();

  tristate_buffer_one_bit #(.CNT_W(CNT_W)) u_dut_pu (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_pu.slave),
    .dout (dout_pu)
  );

  tristate_buffer_one_bit #(.CNT_W(CNT_W)) u_dut_pd (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_pd.slave),
    .dout (dout_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic d, input logic s);
    bus_pu.din = d;
    bus_pu.sel = s;
    bus_pd.din = d;
    bus_pd.sel = s;
  endtask

  task automatic test_unknown_sel();
    drive(1'b1, 1'bx);
    #1;
    checks++;
    if (dout_pu === 1'b1 && dout_pd === 1'b1) begin
      errors++;
      $display("FAIL unknown_sel: dout_pu=%b dout_pd=%b required not a clean drive of din=1", dout_pu, dout_pd);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_pu.drv_q !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_drv_q: got %b required 1", bus_pu.drv_q);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dout_pu !== 1'b1 || dout_pd !== 1'b1) begin
      errors++;
      $display("FAIL reset_dout: dout_pu=%b dout_pd=%b required 1/1", dout_pu, dout_pd);
    end
    checks++;
    if (bus_pu.drv_q !== 1'b0 || bus_pu.drv_rise !== 1'b0) begin
      errors++;
      $display("FAIL reset_sideband: drv_q=%b drv_rise=%b required 0/0", bus_pu.drv_q, bus_pu.drv_rise);
    end
`ifdef TRISTATE_DRIVE_STATS_EN
    checks++;
    if (bus_pu.drv_cycles !== 2'd0) begin
      errors++;
      $display("FAIL reset_drv_cycles: got %0d required 0", bus_pu.drv_cycles);
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if (bus_pu.drv_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: drv_q=%b required 0 while rst held", bus_pu.drv_q);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0);
  endtask

  task automatic test_disabled();
    drive(1'b0, 1'b0);
    #1;
    checks++;
    if (dout_pu !== 1'b1 || dout_pd !== 1'b0) begin
      errors++;
      $display("FAIL disabled_din0: dout_pu=%b dout_pd=%b required undriven 1/0", dout_pu, dout_pd);
    end
    drive(1'b1, 1'b0);
    #1;
    checks++;
    if (dout_pu !== 1'b1 || dout_pd !== 1'b0) begin
      errors++;
      $display("FAIL disabled_din1: dout_pu=%b dout_pd=%b required undriven 1/0", dout_pu, dout_pd);
    end
  endtask

  task automatic test_enabled();
    drive(1'b0, 1'b1);
    #1;
    checks++;
    if (dout_pu !== 1'b0 || dout_pd !== 1'b0) begin
      errors++;
      $display("FAIL enabled_din0: dout_pu=%b dout_pd=%b required 0/0", dout_pu, dout_pd);
    end
    drive(1'b1, 1'b1);
    #1;
    checks++;
    if (dout_pu !== 1'b1 || dout_pd !== 1'b1) begin
      errors++;
      $display("FAIL enabled_din1: dout_pu=%b dout_pd=%b required 1/1", dout_pu, dout_pd);
    end
    drive(1'b0, 1'b1);
    #0;
    #0;
    checks++;
    if (dout_pu !== 1'b0 || dout_pd !== 1'b0) begin
      errors++;
      $display("FAIL enabled_follow: dout_pu=%b dout_pd=%b required 0/0 same timestep", dout_pu, dout_pd);
    end
  endtask

  task automatic test_edge_detect();
    @(negedge clk);
    drive(1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (bus_pu.drv_q !== 1'b1 || bus_pu.drv_rise !== 1'b1) begin
      errors++;
      $display("FAIL rise_first: drv_q=%b drv_rise=%b required 1/1", bus_pu.drv_q, bus_pu.drv_rise);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus_pu.drv_q !== 1'b1 || bus_pu.drv_rise !== 1'b0) begin
        errors++;
        $display("FAIL rise_hold%0d: drv_q=%b drv_rise=%b required 1/0", i, bus_pu.drv_q, bus_pu.drv_rise);
      end
    end
    drive(1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus_pu.drv_q !== 1'b0 || bus_pu.drv_rise !== 1'b0) begin
      errors++;
      $display("FAIL fall: drv_q=%b drv_rise=%b required 0/0", bus_pu.drv_q, bus_pu.drv_rise);
    end
    // A pulse entirely between two rising edges must stay invisible.
    drive(1'b0, 1'b1);
    #2;
    drive(1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus_pu.drv_q !== 1'b0 || bus_pu.drv_rise !== 1'b0) begin
      errors++;
      $display("FAIL narrow_pulse: drv_q=%b drv_rise=%b required 0/0", bus_pu.drv_q, bus_pu.drv_rise);
    end
  endtask

`ifdef TRISTATE_DRIVE_STATS_EN
  task automatic test_counter();
    logic [CNT_W-1:0] exp_steps [5];
    exp_steps = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    drive(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus_pu.drv_cycles !== exp_steps[i]) begin
        errors++;
        $display("FAIL counter_step%0d: got %0d required %0d", i, bus_pu.drv_cycles, exp_steps[i]);
      end
    end
    drive(1'b0, 1'b0);
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    test_unknown_sel();
    test_reset();
    test_disabled();
    test_enabled();
    test_edge_detect();
`ifdef TRISTATE_DRIVE_STATS_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tristate_buffer_one_bit

`default_nettype wire
